// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into instruction memory
//   and holds the core in reset until the whole image has been written.
// Latency: mem_we is asserted 1 cycle after the fourth byte of a word is
//   accepted, so each word takes at least 5 cycles.
// Backpressure: byte_ready is combinational and is high only in LEN_LO, LEN_HI,
//   DATA and CHK. An idle source (byte_valid=0) stalls any state, with no timeout.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 one-cycle load request (honoured in IDLE/DONE/ERR)
//   byte_valid/_data/_ready  byte source handshake
//   mem_we/addr/wdata     one-cycle word write strobe, word index, word data
//   cpu_hold              0 only once a load has completed
//   done, error           load result, held until the next start
//   words_written         count of words written by the current load
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR
// checksum byte (CHK state) that must match the XOR of all data bytes.

module imem_loader (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [8:0]  words_written
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK    = 3'd5,
`endif
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q,   len_d;
   logic [1:0]  lane_q,  lane_d;
   logic [31:0] word_q,  word_d;
   logic [8:0]  wcnt_q,  wcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q,  csum_d;
`endif

   logic        xfer;
   logic [15:0] hdr_len;
   logic [8:0]  wcnt_inc;

   // Full length as it will look once the high header byte lands.
   assign hdr_len  = {byte_data, len_q[7:0]};
   assign wcnt_inc = wcnt_q + 9'd1;
   assign xfer     = byte_valid & byte_ready;

   always_comb begin
      byte_ready = 1'b0;
      case (state_q)
         S_LEN_LO, S_LEN_HI, S_DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK:                      byte_ready = 1'b1;
`endif
         default:                    byte_ready = 1'b0;
      endcase
   end

   // Address and data are gated to zero outside the write cycle so the
   // memory bus is quiet between words and while in reset.
   assign mem_we        = (state_q == S_WRITE);
   assign mem_addr      = mem_we ? {24'd0, wcnt_q[7:0]} : 32'd0;
   assign mem_wdata     = mem_we ? word_q : 32'd0;
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERR);
   assign cpu_hold      = (state_q != S_DONE);
   assign words_written = wcnt_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      lane_d  = lane_q;
      word_d  = word_q;
      wcnt_d  = wcnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN_LO;
               len_d   = 16'd0;
               lane_d  = 2'd0;
               word_d  = 32'd0;
               wcnt_d  = 9'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = 8'd0;
`endif
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = byte_data;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = byte_data;
               // Capping L at 256 keeps every word index within 0..255.
               if (hdr_len == 16'd0 || hdr_len > 16'd256) state_d = S_ERR;
               else                                       state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
               word_d[{lane_q, 3'b000} +: 8] = byte_data;
               lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ byte_data;
`endif
               if (lane_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            wcnt_d = wcnt_inc;
            if ({7'd0, wcnt_inc} < len_q) state_d = S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            else                          state_d = S_CHK;
`else
            else                          state_d = S_DONE;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (xfer) begin
               if (byte_data == csum_q) state_d = S_DONE;
               else                     state_d = S_ERR;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= 16'd0;
         lane_q  <= 2'd0;
         word_q  <= 32'd0;
         wcnt_q  <= 9'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
         wcnt_q  <= wcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected words, addresses and checksums are hand values or bench-computed.

module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [8:0]  words_written;

   int n_pass  = 0;
   int n_total = 0;
   int wr_cnt  = 0;
   int dup_cnt = 0;
   logic prev_we = 1'b0;
   logic [7:0] csum;

   imem_loader dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts write strobes and any strobe lasting longer than one cycle.
   always @(negedge clk) begin
      if (mem_we) begin
         wr_cnt <= wr_cnt + 1;
         if (prev_we) dup_cnt <= dup_cnt + 1;
      end
      prev_we <= mem_we;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      byte_data  = b;
      byte_valid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         if (byte_ready) ok = 1'b1;
         @(negedge clk);
      end
      if (!ok) check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input logic [8:0] addr, input bit stall);
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         if (stall) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         b = w[i*8 +: 8];
         send_byte(b);
         csum = csum ^ b;
      end
      check("we_latency", {31'd0, mem_we}, 32'd1);
      check("wr_addr", mem_addr, {23'd0, addr});
      check("wr_data", mem_wdata, w);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      csum  = 8'd0;
   endtask

   task automatic finish_load(input logic [7:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(c);
`else
      if (c == 8'hFF) @(negedge clk); // keeps c referenced in both builds
      else            @(negedge clk);
`endif
      byte_valid = 1'b0;
   endtask

   task automatic check_done(input string tag, input logic [8:0] ww, input int nwr);
      check({tag, "_done"},  {31'd0, done}, 32'd1);
      check({tag, "_error"}, {31'd0, error}, 32'd0);
      check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
      check({tag, "_ww"},    {23'd0, words_written}, {23'd0, ww});
      check({tag, "_nwr"},   wr_cnt, nwr);
   endtask

   initial begin
      int base;
      logic [31:0] w;
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0; csum = 8'd0;
      #1;
      check("rst_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_we",    {31'd0, mem_we}, 32'd0);
      check("rst_addr",  mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_ww",    {23'd0, words_written}, 32'd0);
      check("rst_hold",  {31'd0, cpu_hold}, 32'd1);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("idle_ready", {31'd0, byte_ready}, 32'd0);

      // Basic single-word load.
      base = wr_cnt;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h12345678, 9'd0, 1'b0);
      finish_load(8'h08);
      check_done("basic", 9'd1, base + 1);

      // Full 256-word image, byte_valid held high throughout.
      base = wr_cnt;
      pulse_start();
      check("restart_done_clr", {31'd0, done}, 32'd0);
      send_byte(8'h00); send_byte(8'h01);
      for (int i = 0; i < 256; i++) begin
         w = {i[7:0] ^ 8'hFF, 8'hA5, i[7:0], 8'h3C ^ i[7:0]};
         send_word(w, i[8:0], 1'b0);
      end
      finish_load(csum);
      check_done("full", 9'd256, base + 256);

      // Zero length.
      base = wr_cnt;
      pulse_start();
      send_byte(8'h00); send_byte(8'h00);
      byte_valid = 1'b0;
      check("len0_error", {31'd0, error}, 32'd1);
      check("len0_done",  {31'd0, done}, 32'd0);
      check("len0_hold",  {31'd0, cpu_hold}, 32'd1);
      check("len0_nwr",   wr_cnt, base);
      // L = 257.
      pulse_start();
      check("restart_err_clr", {31'd0, error}, 32'd0);
      send_byte(8'h01); send_byte(8'h01);
      byte_valid = 1'b0;
      check("len257_error", {31'd0, error}, 32'd1);
      check("len257_nwr",   wr_cnt, base);
      // Recovery with a valid header.
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'hCAFEF00D, 9'd0, 1'b0);
      send_word(32'h0BADBEEF, 9'd1, 1'b0);
      finish_load(csum);
      check_done("recover", 9'd2, base + 2);

      // Random stalls plus an ignored start in the middle of DATA.
      base = wr_cnt;
      pulse_start();
      send_byte(8'h03); send_byte(8'h00);
      send_word(32'h11223344, 9'd0, 1'b1);
      send_byte(8'h99); send_byte(8'h88);
      csum = csum ^ 8'h99 ^ 8'h88;
      byte_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_start_ww",   {23'd0, words_written}, 32'd1);
      check("ign_start_hold", {31'd0, cpu_hold}, 32'd1);
      send_byte(8'h77);
      send_byte(8'h66);
      csum = csum ^ 8'h77 ^ 8'h66;
      check("ign_start_addr",  mem_addr, 32'd1);
      check("ign_start_wdata", mem_wdata, 32'h66778899);
      send_word(32'hDEADC0DE, 9'd2, 1'b1);
      finish_load(csum);
      check_done("stall", 9'd3, base + 3);

      // Reset in the middle of a word.
      base = wr_cnt;
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      byte_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("midrst_hold",  {31'd0, cpu_hold}, 32'd1);
      check("midrst_ready", {31'd0, byte_ready}, 32'd0);
      check("midrst_ww",    {23'd0, words_written}, 32'd0);
      check("midrst_done",  {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_nwr",   wr_cnt, base);
      check("midrst_idle",  {31'd0, byte_ready}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum mismatch: AA^BB^CC^DD = 00, send 11 instead.
      base = wr_cnt;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'hDDCCBBAA, 9'd0, 1'b0);
      send_byte(8'h11);
      byte_valid = 1'b0;
      check("csum_error", {31'd0, error}, 32'd1);
      check("csum_done",  {31'd0, done}, 32'd0);
      check("csum_hold",  {31'd0, cpu_hold}, 32'd1);
      check("csum_nwr",   wr_cnt, base + 1);
`endif

      check("we_one_cycle", dup_cnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide one clock and an asynchronous active-high reset, with ports listed first: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-002 SHALL provide these input ports: start 1, one-cycle load request; byte_valid 1, source byte present; byte_data 8, source byte.
REQ-003 SHALL provide these output ports: byte_ready 1, loader accepts byte; mem_we 1, instruction-memory word write strobe; mem_addr 32, word index, bits 31:8 always 0; mem_wdata 32, word to write; cpu_hold 1, holds core in reset while program is incomplete; done 1, load complete; error 1, load failed; words_written 9, count of words written this load.

Function
REQ-004 SHALL transfer a byte only in a cycle where byte_valid and byte_ready are both 1; all other cycles SHALL be no-transfer.
REQ-005 SHALL implement the states IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE and ERR.
REQ-006 SHALL assert byte_ready combinationally only in LEN_LO, LEN_HI, DATA and CHK.
REQ-007 SHALL move from IDLE, DONE or ERR to LEN_LO on start=1, clearing words_written, the byte lane, the length register, done and error; start SHALL be ignored in every other state.
REQ-008 SHALL form the 16-bit word length L from a little-endian header: the LEN_LO transfer gives L[7:0], then LEN_HI, and the LEN_HI transfer gives L[15:8].
REQ-009 SHALL go from LEN_HI to ERR if L==0 or L>256; otherwise it SHALL go to DATA.
REQ-010 SHALL assemble each word little-endian in DATA: the first byte goes to [7:0] and the fourth to [31:24], and a 2-bit lane counter wraps 3->0.
REQ-011 SHALL enter WRITE in the cycle after the fourth byte transfer.
REQ-012 SHALL hold mem_we=1 for exactly that one WRITE cycle, with mem_wdata set to the assembled word and mem_addr set to words_written zero-extended.
REQ-013 SHALL increment words_written at the end of the WRITE cycle.
REQ-014 SHALL leave WRITE for DATA if the incremented words_written is less than L; otherwise it SHALL go to CHK, or to DONE when the checksum feature is compiled out (see REQ-021..022).
REQ-015 SHALL keep the latency from the fourth byte transfer to mem_we at 1 cycle, with a minimum of 5 cycles per word.
REQ-016 SHALL let the address wrap only by design: L<=256 guarantees that mem_addr never exceeds 255.
REQ-017 SHALL hold done=1 in DONE and error=1 in ERR, each until the next start; cpu_hold SHALL be 0 only in DONE.
REQ-018 SHALL keep mem_we=0 in all states except WRITE, with no write ever issued in ERR.
REQ-019 SHALL make an idle source (byte_valid=0) stall any state indefinitely, with no timeout.

Reset
REQ-020 SHALL, on reset=1 at any time including mid-load, immediately go to IDLE with mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, words_written=0, cpu_hold=1 and byte_ready=0; a partial word SHALL be discarded and not written.

Configuration
REQ-021 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, accumulate the XOR of all data bytes; after the last write it SHALL accept one byte in CHK, go to DONE on a match and to ERR otherwise.
REQ-022 SHALL, without IMEM_LOADER_CHECKSUM_EN, contain no CHK state or checksum register, and WRITE of the last word SHALL go straight to DONE.

Verification
REQ-023 SHALL cover a basic load: after reset, start, then bytes 01 00 78 56 34 12 (+ checksum 08 if _EN) -> one mem_we with mem_addr=0 and mem_wdata=32'h12345678, then done=1, cpu_hold=0 and words_written=1.
REQ-024 SHALL cover a full image: L=256, bytes 00 01, then 1024 data bytes with byte_valid held 1 -> 256 writes at addresses 0..255, each mem_we exactly one cycle after its fourth byte, and words_written=256.
REQ-025 SHALL cover bad lengths: header 00 00 -> error=1 with no mem_we; header 01 01 (L=257) -> error=1; then start with a valid header -> normal load.
REQ-026 SHALL cover stalls and ignored start: byte_valid toggled randomly with a start pulse mid-DATA -> identical written words and the start ignored.
REQ-027 SHALL cover reset mid-word: reset asserted after 2 data bytes -> IDLE, cpu_hold=1, and no mem_we for the partial word.
REQ-028 SHALL cover checksum mismatch with _EN: L=1, data AA BB CC DD, checksum 00 (expected 00? use 11) -> error=1, cpu_hold=1 and done=0.
